alu_exec: RTL and testbench

- Execute/writeback stage directly upstream of the 8-bit ALU.
- Accepts one instruction at a time over a valid/ready handshake and reads operands from a small register file.
- Drives the ALU operand, carry and opcode inputs from registered values, then captures the ALU result and flags.
- Writes the result back to the register file and presents it downstream over a second valid/ready handshake.

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_regfile.sv | 26 ++
 rtl/alu_exec.sv | 90 +++++++++
 tb/tb_alu_exec.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and data width shared by the ALU execute stage
package alu_pkg;
  localparam int DW = 8;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADC  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SBC  = 4'd3;
  localparam logic [3:0] OP_PASS = 4'd4;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } st_e;
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NREG x DW registers, two combinational read ports, one synchronous write port
module alu_regfile
  import alu_pkg::*;
#(
  parameter int NREG = 4,
  parameter int RA_W = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [RA_W-1:0] wa,
  input  logic [DW-1:0]   wd,
  input  logic [RA_W-1:0] ra0,
  output logic [DW-1:0]   rd0,
  input  logic [RA_W-1:0] ra1,
  output logic [DW-1:0]   rd1
);
  logic [DW-1:0] r_mem [NREG];
  assign rd0 = r_mem[ra0];
  assign rd1 = r_mem[ra1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    else if (we)
      r_mem[wa] <= wd;
endmodule

// File: rtl/alu_exec.sv
// alu_exec: execute/writeback stage feeding an external combinational 8-bit ALU.
// Define ALU_EXEC_BACK2BACK_EN to accept the next instruction while the result is consumed.
module alu_exec
  import alu_pkg::*;
#(
  parameter int NREG = 4,
  parameter int RA_W = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [RA_W-1:0] in_rd,
  input  logic [RA_W-1:0] in_rs,
  input  logic [DW-1:0]   in_imm,
  input  logic            in_use_imm,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic            alu_carry,
  output logic [3:0]      alu_op,
  input  logic [DW-1:0]   alu_c,
  input  logic            alu_carry_out,
  input  logic            alu_zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic            out_carry,
  output logic            out_zero
);
  st_e             r_state;
  logic [DW-1:0]   r_a, r_b, r_res;
  logic [3:0]      r_op;
  logic [RA_W-1:0] r_rd;
  logic            r_cin, r_carry, r_zero;
  logic [DW-1:0]   w_ra, w_rb;
  logic            w_acc;
  alu_regfile #(.NREG(NREG), .RA_W(RA_W)) u_rf (
    .clk(clk), .rst_n(rst_n),
    .we(r_state == ST_EXEC), .wa(r_rd), .wd(alu_c),
    .ra0(in_rd), .rd0(w_ra),
    .ra1(in_rs), .rd1(w_rb)
  );
`ifdef ALU_EXEC_BACK2BACK_EN
  assign in_ready = rst_n && (r_state == ST_IDLE || (r_state == ST_RESP && out_ready));
`else
  assign in_ready = rst_n && r_state == ST_IDLE;
`endif
  assign w_acc     = in_valid && in_ready;
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_op    = r_op;
  assign alu_carry = r_cin;
  assign out_valid = r_state == ST_RESP;
  assign out_data  = r_res;
  assign out_carry = r_carry;
  assign out_zero  = r_zero;
  // Acceptance only happens in IDLE or a consumed RESP, so it takes priority over the state walk.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_rd    <= '0;
      r_cin   <= 1'b0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_acc) begin
      r_a     <= w_ra;
      r_b     <= in_use_imm ? in_imm : w_rb;
      r_op    <= in_op;
      r_rd    <= in_rd;
      r_cin   <= r_carry;
      r_state <= ST_EXEC;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_IDLE;
        ST_EXEC: begin
          r_res   <= alu_c;
          r_carry <= alu_carry_out;
          r_zero  <= alu_zero;
          r_state <= ST_RESP;
        end
        ST_RESP: r_state <= out_ready ? ST_IDLE : ST_RESP;
        default: r_state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed self-checking bench for alu_exec with a behavioural ALU attached
module tb_alu_exec;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       in_valid = 1'b0, in_ready, in_use_imm = 1'b0, out_ready = 1'b0;
  logic [3:0] in_op = '0, alu_op;
  logic [1:0] in_rd = '0, in_rs = '0;
  logic [7:0] in_imm = '0, alu_a, alu_b, alu_c, out_data;
  logic       alu_carry, alu_carry_out, alu_zero, out_valid, out_carry, out_zero;
  logic [8:0] t;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  alu_exec dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_imm(in_imm), .in_use_imm(in_use_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_carry(alu_carry), .alu_op(alu_op),
    .alu_c(alu_c), .alu_carry_out(alu_carry_out), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_carry(out_carry), .out_zero(out_zero)
  );

  always_comb begin
    case (alu_op)
      4'd0:    t = {1'b0, alu_a} + {1'b0, alu_b};
      4'd1:    t = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_carry};
      4'd2:    t = {1'b0, alu_a} - {1'b0, alu_b};
      4'd3:    t = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_carry};
      default: t = {1'b0, alu_a};
    endcase
    alu_c         = t[7:0];
    alu_carry_out = t[8];
    alu_zero      = t[7:0] == 8'd0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                     input logic [7:0] imm, input logic ui, input logic cin,
                     input logic [7:0] ed, input logic ec, input logic ez, input int hold);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1'b1);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs = rs; in_imm = imm; in_use_imm = ui;
    @(negedge clk);
    in_valid = 1'b0;
    chk("exec_alu_op", alu_op, op);
    chk("exec_alu_carry", alu_carry, cin);
    chk("exec_out_valid", out_valid, 1'b0);
    @(negedge clk);
    for (int i = 0; i < hold; i++) begin
      chk("hold_out_valid", out_valid, 1'b1);
      chk("hold_out_data", out_data, ed);
      chk("hold_in_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    chk("resp_out_valid", out_valid, 1'b1);
    chk("resp_out_data", out_data, ed);
    chk("resp_out_carry", out_carry, ec);
    chk("resp_out_zero", out_zero, ez);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    fails++;
    $error("FAIL timeout: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #12;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_alu_a", alu_a, 8'h00);
    chk("rst_alu_op", alu_op, 4'h0);
    rst_n = 1'b1;
    run(4'd0, 2'd0, 2'd0, 8'h05, 1'b1, 1'b0, 8'h05, 1'b0, 1'b0, 0);
    run(4'd0, 2'd0, 2'd0, 8'hF0, 1'b1, 1'b0, 8'hF5, 1'b0, 1'b0, 0);
    run(4'd2, 2'd0, 2'd0, 8'h05, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0, 0);
    run(4'd0, 2'd0, 2'd0, 8'h20, 1'b1, 1'b0, 8'h10, 1'b1, 1'b0, 0);
    run(4'd1, 2'd1, 2'd0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 0);
    run(4'd0, 2'd2, 2'd0, 8'h05, 1'b1, 1'b0, 8'h05, 1'b0, 1'b0, 0);
    run(4'd2, 2'd2, 2'd0, 8'h05, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 0);
    run(4'd2, 2'd2, 2'd0, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 0);
    run(4'd0, 2'd3, 2'd0, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 0);
    run(4'd9, 2'd3, 2'd0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 5);
    run(4'd0, 2'd3, 2'd3, 8'h00, 1'b0, 1'b0, 8'h4A, 1'b1, 1'b0, 0);
    run(4'd3, 2'd0, 2'd1, 8'h00, 1'b0, 1'b1, 8'h0E, 1'b0, 1'b0, 0);
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'd0; in_rd = 2'd1; in_imm = 8'h33; in_use_imm = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_alu_b", alu_b, 8'h33);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_alu_b", alu_b, 8'h00);
    chk("mid_rst_out_data", out_data, 8'h00);
    chk("mid_rst_out_carry", out_carry, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_out_valid", out_valid, 1'b0);
    run(4'd4, 2'd1, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0);
    run(4'd4, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0);
`ifdef ALU_EXEC_BACK2BACK_EN
    begin
      int acc = 0, outs = 0, last = -1;
      @(negedge clk);
      in_valid = 1'b1; in_op = 4'd0; in_rd = 2'd0; in_imm = 8'h01; in_use_imm = 1'b1; out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
        if (out_valid) begin
          outs++;
          chk("b2b_out_data", out_data, 8'(outs));
          if (last >= 0) chk("b2b_spacing", c - last, 2);
          last = c;
        end
        if (acc == 4) in_valid = 1'b0;
        if (in_valid && in_ready) acc++;
        @(negedge clk);
      end
      out_ready = 1'b0;
      chk("b2b_out_count", outs, 4);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
